// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage, valid/ready streaming.
// Define PIPE_ADDSUB_FLAGS_EN to add the overflow and zero flag outputs.
module pipelined_addsub #(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int STAGES = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef PIPE_ADDSUB_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  // The whole pipe moves or freezes as one unit, so bubbles keep their slots.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : stage
    localparam int UP = WIDTH - (k + 1) * CHUNK;

    logic                   v_in;
    logic                   c_in;
    logic [CHUNK-1:0]       a_sl;
    logic [CHUNK-1:0]       b_sl;
    logic [CHUNK:0]         part;
    logic [(k+1)*CHUNK-1:0] s_next;
    logic                   v_q;
    logic                   c_q;
    logic [(k+1)*CHUNK-1:0] s_q;

    if (k == 0) begin : src
      assign v_in   = in_valid;
      assign c_in   = sub;
      assign a_sl   = a[CHUNK-1:0];
      assign b_sl   = b_eff[CHUNK-1:0];
      assign s_next = part[CHUNK-1:0];
    end else begin : src
      assign v_in   = stage[k-1].v_q;
      assign c_in   = stage[k-1].c_q;
      assign a_sl   = stage[k-1].ops.a_q[CHUNK-1:0];
      assign b_sl   = stage[k-1].ops.b_q[CHUNK-1:0];
      assign s_next = {part[CHUNK-1:0], stage[k-1].s_q};
    end

    assign part = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= part[CHUNK];
        s_q <= s_next;
      end
    end

    // Only the operand slices still to be added are carried forward.
    if (k < STAGES - 1) begin : ops
      logic [UP-1:0] a_up;
      logic [UP-1:0] b_up;
      logic [UP-1:0] a_q;
      logic [UP-1:0] b_q;

      if (k == 0) begin : up_src
        assign a_up = a[WIDTH-1:CHUNK];
        assign b_up = b_eff[WIDTH-1:CHUNK];
      end else begin : up_src
        assign a_up = stage[k-1].ops.a_q[UP+CHUNK-1:CHUNK];
        assign b_up = stage[k-1].ops.b_q[UP+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_up;
          b_q <= b_up;
        end
      end
    end

`ifdef PIPE_ADDSUB_FLAGS_EN
    logic am_in;
    logic bm_in;
    logic z_in;
    logic am_q;
    logic bm_q;
    logic z_q;

    if (k == 0) begin : flag_src
      assign am_in = a[WIDTH-1];
      assign bm_in = b_eff[WIDTH-1];
      assign z_in  = 1'b1;
    end else begin : flag_src
      assign am_in = stage[k-1].am_q;
      assign bm_in = stage[k-1].bm_q;
      assign z_in  = stage[k-1].z_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        am_q <= 1'b0;
        bm_q <= 1'b0;
        z_q  <= 1'b0;
      end else if (advance) begin
        am_q <= am_in;
        bm_q <= bm_in;
        z_q  <= z_in && (part[CHUNK-1:0] == '0);
      end
    end
`endif
  end

  assign out_valid = stage[STAGES-1].v_q;
  assign sum       = stage[STAGES-1].s_q;
  assign carry_out = stage[STAGES-1].c_q;

`ifdef PIPE_ADDSUB_FLAGS_EN
  assign overflow = (stage[STAGES-1].am_q == stage[STAGES-1].bm_q) &&
                    (sum[WIDTH-1] != stage[STAGES-1].am_q);
  assign zero     = stage[STAGES-1].z_q;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (32-bit, 8-bit chunks, latency 4).
// Flag checks are compiled in when PIPE_ADDSUB_FLAGS_EN is defined.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry_out;
`ifdef PIPE_ADDSUB_FLAGS_EN
  logic        overflow;
  logic        zero;
`endif

  pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef PIPE_ADDSUB_FLAGS_EN
    ,
    .overflow  (overflow),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        ovf;
    logic        z;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   lat_check = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.sum = s; e.c = c; e.ovf = o; e.z = z; e.acc = 0; e.chk_lat = 1'b0;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    logic [31:0] bb;
    logic [32:0] r;
    bb = ts ? ~tb : tb;
    r  = {1'b0, ta} + {1'b0, bb} + {32'd0, ts};
    return mk(r[31:0], r[32], (ta[31] == bb[31]) && (r[31] != ta[31]), r[31:0] == 32'd0);
  endfunction

  // Present one operation, retrying while in_ready is low; expectation queued on acceptance.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                               input exp_t e);
    in_valid = 1'b1; a = ta; b = tb; sub = ts;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        e.chk_lat = lat_check;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] held_sum;
  logic        held_c;
  logic        held_o;
  logic        held_z;
  bit          stalled = 1'b0;

  // Output monitor: stall stability, in_ready under backpressure, in-order scoreboard pops.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_sum", 64'(sum), 64'(held_sum));
        checkOutput("hold_carry", 64'(carry_out), 64'(held_c));
`ifdef PIPE_ADDSUB_FLAGS_EN
        checkOutput("hold_overflow", 64'(overflow), 64'(held_o));
        checkOutput("hold_zero", 64'(zero), 64'(held_z));
`endif
      end
      if (out_valid && !out_ready) begin
        checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
        stalled  = 1'b1;
        held_sum = sum;
        held_c   = carry_out;
`ifdef PIPE_ADDSUB_FLAGS_EN
        held_o   = overflow;
        held_z   = zero;
`endif
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        checkOutput("result_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sum", 64'(sum), 64'(e.sum));
          checkOutput("carry_out", 64'(carry_out), 64'(e.c));
`ifdef PIPE_ADDSUB_FLAGS_EN
          checkOutput("overflow", 64'(overflow), 64'(e.ovf));
          checkOutput("zero", 64'(zero), 64'(e.z));
`endif
          if (e.chk_lat) checkOutput("latency", 64'(cyc - e.acc), 64'd4);
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_sum", 64'(sum), 64'd0);
    checkOutput("reset_carry", 64'(carry_out), 64'd0);
`ifdef PIPE_ADDSUB_FLAGS_EN
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    checkOutput("reset_zero", 64'(zero), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed boundary cases");
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    applyStimulus(32'd5, 32'd7, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    applyStimulus(32'd7, 32'd5, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0, 1'b0));
    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    applyStimulus(32'h8000_0000, 32'd1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    waitDrain();

    $display("[TB] streaming back-to-back");
    for (int i = 0; i < 8; i++)
      applyStimulus(32'(i), 32'(i * 32'h100), i[0], model(32'(i), 32'(i * 32'h100), i[0]));
    waitDrain();

    $display("[TB] backpressure");
    lat_check = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] ra;
          logic [31:0] rb;
          ra = $urandom;
          rb = $urandom;
          applyStimulus(ra, rb, i[0], model(ra, rb, i[0]));
        end
      end
      begin
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        checkOutput("bp_filled", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain();
    lat_check = 1'b1;

    $display("[TB] reset mid-flight");
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, model(32'h1234_5678, 32'h1111_1111, 1'b0));
    applyStimulus(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b1, model(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b1));
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_sum", 64'(sum), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0, 1'b0));
    waitDrain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
